// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO access arbiter
package fifo_arb_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_DATA_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDATA = 2'd3
    } arb_state_e;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } arb_op_e;

endpackage

// File: rtl/fifo_access_arbiter_if.sv
// rtl/fifo_access_arbiter_if.sv - requester, consumer and FIFO-side signal bundle
interface fifo_access_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rd_req;
    logic                      rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      fifo_rd_en;
    logic [DATA_W-1:0]         fifo_rd_data;
    logic [ID_W-1:0]           grant_id;

    // master is the arbiter; slave is the surrounding producers, consumer and FIFO
    modport master (
        input  req_valid, req_data, rd_req, fifo_full, fifo_empty, fifo_rd_data,
        output req_ready, rd_valid, rd_data, fifo_wr_en, fifo_wr_data, fifo_rd_en, grant_id
    );

    modport slave (
        output req_valid, req_data, rd_req, fifo_full, fifo_empty, fifo_rd_data,
        input  req_ready, rd_valid, rd_data, fifo_wr_en, fifo_wr_data, fifo_rd_en, grant_id
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin finder: first set req bit at or after ptr
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] at_or_above;
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] sel;
    logic [NUM_REQ-1:0] sh;

    // Prefer requests at or above ptr; if none, wrap to the lowest request overall.
    always_comb begin
        at_or_above = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
        hi          = req & at_or_above;
        sel         = (hi != '0) ? hi : req;
        found       = (req != '0);
        idx         = '0;
        sh          = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sh = sel >> i;
            if (sh[0]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - arbitrates several writers and one reader onto a single FIFO
module fifo_access_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    fifo_access_arbiter_if.master bus
);

    arb_state_e state_q, state_d;
    arb_op_e    last_op_q, last_op_d;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic               rd_valid_q, rd_valid_d;

    logic                      pick_found;
    logic [ID_W-1:0]           pick_idx;
    logic [NUM_REQ*DATA_W-1:0] data_sh;
    logic                      wr_ok, rd_ok, take_wr, take_rd;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign wr_ok   = pick_found && !bus.fifo_full;
    assign rd_ok   = bus.rd_req && !bus.fifo_empty;
    // On a tie, whichever operation did not run last goes next.
    assign take_wr = ena && wr_ok && (!rd_ok || (last_op_q == OP_RD));
    assign take_rd = ena && rd_ok && !take_wr;
    assign data_sh = bus.req_data >> (int'(pick_idx) * DATA_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_wr) begin
                    state_d = WR;
                end else if (take_rd) begin
                    state_d = RD;
                end
            end
            WR:      state_d = IDLE;
            RD:      state_d = RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        last_op_d   = last_op_q;
        grant_id_d  = grant_id_q;
        wr_data_d   = wr_data_q;
        req_ready_d = '0;
        wr_en_d     = (state_d == WR);
        rd_en_d     = (state_d == RD);
        rd_valid_d  = (state_d == RDATA);
        if ((state_q == IDLE) && (state_d == WR)) begin
            req_ready_d = NUM_REQ'(1) << pick_idx;
            grant_id_d  = pick_idx;
            wr_data_d   = data_sh[DATA_W-1:0];
            rr_ptr_d    = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            last_op_d   = OP_WR;
        end
        if ((state_q == IDLE) && (state_d == RD)) begin
            last_op_d = OP_RD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            last_op_q   <= OP_RD;
            grant_id_q  <= '0;
            wr_data_q   <= '0;
            req_ready_q <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            last_op_q   <= last_op_d;
            grant_id_q  <= grant_id_d;
            wr_data_q   <= wr_data_d;
            req_ready_q <= req_ready_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.fifo_rd_en   = rd_en_q;
    assign bus.rd_valid     = rd_valid_q;
    // Read data flows straight from the FIFO and is only meaningful under the strobe.
    assign bus.rd_data      = rd_valid_q ? bus.fifo_rd_data : '0;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - self-checking bench for fifo_access_arbiter
module tb_fifo_access_arbiter;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    fifo_access_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    fifo_access_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic set_idle();
        ena              = 1'b1;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.rd_req       = 1'b0;
        bus.fifo_full    = 1'b0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        bus.req_valid    = 4'b1111;
        bus.rd_req       = 1'b1;
        bus.fifo_empty   = 1'b0;
        bus.fifo_rd_data = 4'h9;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.fifo_wr_en); end
        vectors++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", bus.fifo_rd_en); end
        vectors++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
        vectors++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", bus.grant_id); end
        vectors++; if (bus.fifo_wr_data !== 4'h0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", bus.fifo_wr_data); end
        vectors++; if (bus.rd_data !== 4'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); end
        set_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        logic [15:0] d;
        do_reset();
        d = 16'($urandom);
        d[11:8] = 4'hA;
        bus.req_data  = d;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        vectors++; if (bus.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got %b exp 1", bus.fifo_wr_en); end
        vectors++; if (bus.fifo_wr_data !== 4'hA) begin errors++; $display("FAIL single_wr_data got %h exp a", bus.fifo_wr_data); end
        vectors++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready got %b exp 0100", bus.req_ready); end
        vectors++; if (bus.grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id got %0d exp 2", bus.grant_id); end
        bus.req_valid = '0;
        @(negedge clk);
        vectors++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single_wr_en_drop got %b exp 0", bus.fifo_wr_en); end
        vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop got %b exp 0000", bus.req_ready); end
        bus.req_valid = 4'b1111;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL single_next_ptr got %b exp 1000", bus.req_ready); end
        vectors++; if (bus.grant_id !== 2'd3) begin errors++; $display("FAIL single_next_grant got %0d exp 3", bus.grant_id); end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [15:0] d;
        logic [3:0]  nib;
        logic [3:0]  exp_rdy;
        do_reset();
        d = 16'($urandom);
        bus.req_data  = d;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_rdy = (c % 2 == 0) ? 4'(1 << ((c / 2) % N)) : 4'b0000;
            nib     = 4'(d >> (4 * ((c / 2) % N)));
            vectors++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c=%0d got %b exp %b", c, bus.req_ready, exp_rdy); end
            vectors++; if (bus.fifo_wr_en !== (c % 2 == 0)) begin errors++; $display("FAIL rr_wr_en c=%0d got %b exp %b", c, bus.fifo_wr_en, (c % 2 == 0)); end
            if (c % 2 == 0) begin
                vectors++; if (bus.fifo_wr_data !== nib) begin errors++; $display("FAIL rr_wr_data c=%0d got %h exp %h", c, bus.fifo_wr_data, nib); end
            end
        end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_alternate();
        logic [3:0] head;
        int p;
        do_reset();
        bus.req_data   = 16'($urandom);
        bus.req_valid  = 4'b0001;
        bus.rd_req     = 1'b1;
        bus.fifo_empty = 1'b0;
        head = 4'h0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            p = c % 5;
            vectors++; if (bus.fifo_wr_en !== (p == 0)) begin errors++; $display("FAIL alt_wr_en c=%0d got %b exp %b", c, bus.fifo_wr_en, (p == 0)); end
            vectors++; if (bus.fifo_rd_en !== (p == 2)) begin errors++; $display("FAIL alt_rd_en c=%0d got %b exp %b", c, bus.fifo_rd_en, (p == 2)); end
            vectors++; if (bus.rd_valid !== (p == 3)) begin errors++; $display("FAIL alt_rd_valid c=%0d got %b exp %b", c, bus.rd_valid, (p == 3)); end
            if (p == 3) begin
                vectors++; if (bus.rd_data !== head) begin errors++; $display("FAIL alt_rd_data c=%0d got %h exp %h", c, bus.rd_data, head); end
            end
            if (p == 2) begin
                head = 4'($urandom);
                bus.fifo_rd_data = head;
            end
        end
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_full_empty();
        do_reset();
        bus.fifo_full  = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.req_valid  = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en c=%0d got %b exp 0", c, bus.fifo_wr_en); end
            vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL full_ready c=%0d got %b exp 0000", c, bus.req_ready); end
        end
        bus.fifo_full  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.req_valid  = '0;
        bus.rd_req     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL empty_rd_en c=%0d got %b exp 0", c, bus.fifo_rd_en); end
        end
        bus.fifo_full  = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.req_valid  = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if (bus.fifo_rd_en !== (c == 0 || c == 3)) begin errors++; $display("FAIL fullrd_rd_en c=%0d got %b exp %b", c, bus.fifo_rd_en, (c == 0 || c == 3)); end
            vectors++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL fullrd_wr_en c=%0d got %b exp 0", c, bus.fifo_wr_en); end
        end
        bus.fifo_full = 1'b0;
        @(negedge clk);
        vectors++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL unfull_wait got %b exp 0", bus.fifo_wr_en); end
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL unfull_ready got %b exp 0001", bus.req_ready); end
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_ena();
        do_reset();
        bus.req_data  = 16'($urandom);
        bus.req_valid = 4'b1111;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL ena_first got %b exp 0001", bus.req_ready); end
        ena = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++; if (bus.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL ena_off_wr_en c=%0d got %b exp 0", c, bus.fifo_wr_en); end
        end
        ena = 1'b1;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL ena_resume_ready got %b exp 0010", bus.req_ready); end
        vectors++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL ena_resume_grant got %0d exp 1", bus.grant_id); end
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        bus.rd_req     = 1'b1;
        bus.fifo_empty = 1'b0;
        @(negedge clk);
        vectors++; if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL midrst_pre_rd_en got %b exp 1", bus.fifo_rd_en); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en got %b exp 0", bus.fifo_rd_en); end
        vectors++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid got %b exp 0", bus.rd_valid); end
        vectors++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b exp 0000", bus.req_ready); end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        vectors++; if (bus.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL midrst_tie_wr_en got %b exp 1", bus.fifo_wr_en); end
        vectors++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_tie_ready got %b exp 0001", bus.req_ready); end
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] fq[$];
        logic [3:0] e_ready, e_wdata, e_rdata, n_rdata, vtmp;
        logic       e_wr, e_rd, e_rv, n_rv, w_ok, r_ok, m_last_wr;
        int         m_ptr, m_busy, m_grant, win, j;
        do_reset();
        fq.delete();
        e_wr = 0; e_rd = 0; e_rv = 0; n_rv = 0; e_ready = '0;
        e_wdata = '0; e_rdata = '0; n_rdata = '0;
        m_ptr = 0; m_busy = 0; m_grant = 0; m_last_wr = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            vectors++; if (bus.fifo_wr_en !== e_wr) begin errors++; $display("FAIL rnd_wr_en cyc=%0d got %b exp %b", cyc, bus.fifo_wr_en, e_wr); end
            vectors++; if (bus.fifo_rd_en !== e_rd) begin errors++; $display("FAIL rnd_rd_en cyc=%0d got %b exp %b", cyc, bus.fifo_rd_en, e_rd); end
            vectors++; if (bus.rd_valid !== e_rv) begin errors++; $display("FAIL rnd_rd_valid cyc=%0d got %b exp %b", cyc, bus.rd_valid, e_rv); end
            vectors++; if (bus.req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, bus.req_ready, e_ready); end
            vectors++; if (bus.grant_id !== 2'(m_grant)) begin errors++; $display("FAIL rnd_grant cyc=%0d got %0d exp %0d", cyc, bus.grant_id, m_grant); end
            if (e_wr) begin
                vectors++; if (bus.fifo_wr_data !== e_wdata) begin errors++; $display("FAIL rnd_wr_data cyc=%0d got %h exp %h", cyc, bus.fifo_wr_data, e_wdata); end
            end
            if (e_rv) begin
                vectors++; if (bus.rd_data !== e_rdata) begin errors++; $display("FAIL rnd_rd_data cyc=%0d got %h exp %h", cyc, bus.rd_data, e_rdata); end
            end
            // FIFO environment acts on the strobes expected at the coming edge
            if (e_wr) fq.push_back(e_wdata);
            if (e_rd) bus.fifo_rd_data = fq.pop_front();
            bus.fifo_full  = (fq.size() == DEPTH);
            bus.fifo_empty = (fq.size() == 0);
            ena            = ($urandom_range(0, 7) != 0);
            bus.req_valid  = 4'($urandom);
            bus.req_data   = 16'($urandom);
            bus.rd_req     = ($urandom_range(0, 2) != 0);
            // reference: one transaction per decision, then a fixed number of busy edges
            e_wr = 0; e_rd = 0; e_ready = '0;
            e_rv = n_rv; e_rdata = n_rdata; n_rv = 0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (ena) begin
                w_ok = (bus.req_valid != '0) && !bus.fifo_full;
                r_ok = bus.rd_req && !bus.fifo_empty;
                if (w_ok && (!r_ok || !m_last_wr)) begin
                    win = -1;
                    for (int k = 0; k < N; k++) begin
                        j = (m_ptr + k) % N;
                        vtmp = bus.req_valid >> j;
                        if (win < 0 && vtmp[0]) win = j;
                    end
                    e_wr = 1; e_ready = 4'(1 << win); e_wdata = 4'(bus.req_data >> (4 * win));
                    m_grant = win; m_ptr = (win + 1) % N; m_last_wr = 1'b1; m_busy = 1;
                end else if (r_ok) begin
                    e_rd = 1; n_rv = 1; n_rdata = fq[0]; m_last_wr = 1'b0; m_busy = 2;
                end
            end
        end
        set_idle();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_alternate();
        test_full_empty();
        test_ena();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fifo_access_arbiter.md
# fifo_access_arbiter

Sequencer and arbiter that shares the single 4-bit FIFO between several write requesters and one read consumer. It converts per-requester valid/ready handshakes and a consumer read request into the FIFO's one-cycle write/read-enable pulses. It respects the FIFO `full` and `empty` flags and interleaves reads and writes fairly. The block sits between the tile's input pins / upstream producers and the FIFO core, inside the same `tt_um_` top.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of write requesters, 2..8.
- `DATA_W`, default 4: FIFO data width.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: arbitration enable. When 0, no new grants; an in-flight operation completes.
- `req_valid`  in  NUM_REQ: per-requester write request. Held with its data until acknowledged.
- `req_data`  in  NUM_REQ*DATA_W: requester i's data at bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ: one-hot, one-cycle acknowledge. The transfer is complete at the edge where it is sampled high.
- `rd_req`  in  1: consumer read request (level).
- `rd_valid`  out  1: one-cycle strobe marking `rd_data` valid.
- `rd_data`  out  DATA_W: read data, passed through from the FIFO.
- `fifo_full`  in  1: FIFO full flag.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_wr_en`  out  1: FIFO write enable.
- `fifo_wr_data`  out  DATA_W: FIFO write data.
- `fifo_rd_en`  out  1: FIFO read enable.
- `fifo_rd_data`  in  DATA_W: FIFO read data, valid the cycle after the edge that sampled `fifo_rd_en`.
- `grant_id`  out  ID_W: index of the last granted requester.

## Operation

FSM states: `IDLE`, `WR`, `RD`, `RDATA`.

Eligibility, evaluated in `IDLE` with `ena=1`:
- Write is eligible when `|req_valid && !fifo_full`.
- Read is eligible when `rd_req && !fifo_empty`.

Decision rules in `IDLE`:
- Only write eligible → `WR`.
- Only read eligible → `RD`.
- Both eligible → the opposite of `last_op`.
- Neither eligible, or `ena=0` → stay in `IDLE`.

Write grant:
- Round-robin search over `req_valid`, starting at `rr_ptr`; the winner is i.
- On entering `WR`:
  - `fifo_wr_data` is registered from `req_data[i]`.
  - `req_ready[i]` = 1.
  - `grant_id` = i.
  - `rr_ptr` ← (i+1) mod NUM_REQ.
  - `last_op` ← WR.
- In `WR`: `fifo_wr_en`=1 for exactly that one cycle, then return to `IDLE`.

Read:
- In `RD`: `fifo_rd_en`=1 for one cycle; `last_op` ← RD; then go to `RDATA`.
- In `RDATA`: `rd_valid`=1 and `rd_data`=`fifo_rd_data`; then return to `IDLE`.

General rules:
- No grant is made from `WR`, `RD` or `RDATA`. This guarantees the flags sampled in `IDLE` already reflect the previous operation.
- A requester whose `req_valid` drops before its grant is simply skipped. No error is raised.
- `rd_req` dropping while in `RD` or `RDATA` does not abort the read; the strobe is still issued.

Reset values:
- All outputs are 0.
- State = `IDLE`, `rr_ptr` = 0, `last_op` = RD, so writes win the first tie.

Reset asserted mid-operation:
- Immediate clear to the reset values; any pending pulse is dropped.
- The FIFO is reset by the same `rst_n`, so no partial transfer survives.

## Timing

- Write: decision at edge E. `req_ready[i]` and `fifo_wr_en` are high during cycle E..E+1. The FIFO writes at E+1. The next decision is at E+2.
  - Sustained write throughput is 1 per 2 cycles.
- Read: decision at E. `fifo_rd_en` is high during E..E+1. `rd_valid` is high during E+1..E+2. The consumer samples at E+2. The next decision is at E+3.
- `fifo_full` / `fifo_empty` are sampled only in `IDLE`, at the decision edge.
- Boundaries:
  - Full → writes are stalled and reads proceed.
  - Empty → reads are stalled and writes proceed.
  - Full and `rd_req` → read only.
- `rr_ptr` wraps from NUM_REQ-1 to 0.
- All outputs are registered except `rd_data`, which is a FIFO pass-through gated only by `rd_valid` semantics.

## Structure

- Package `fifo_arb_pkg` holds:
  - the state enum (`IDLE`, `WR`, `RD`, `RDATA`);
  - the op enum for `last_op` (`OP_WR`, `OP_RD`);
  - the default `NUM_REQ` / `DATA_W` constants.
- One sub-module, `rr_pick`: combinational round-robin priority finder. Inputs are `req` and `ptr`; outputs are `found` and index `idx`. It is parameterized by `NUM_REQ`.

## Test plan

- Reset, then requester 2 valid with data 4'hA → `fifo_wr_en` one cycle with `fifo_wr_data`=4'hA, `req_ready`=4'b0100, `grant_id`=2, `rr_ptr`=3.
- All four requesters valid continuously, FIFO never full → grants in order 0,1,2,3,0, each 2 cycles apart; each `req_ready` one-hot for one cycle.
- One write valid and `rd_req`=1 with FIFO non-empty → ops alternate WR, RD, WR, RD, starting with WR after reset. `rd_valid` is asserted 2 cycles after each RD decision and carries the FIFO head value.
- `fifo_full`=1 with writers valid and `rd_req`=0 → no `fifo_wr_en` and no `req_ready` until full drops. `fifo_empty`=1 with `rd_req`=1 → no `fifo_rd_en`.
- `ena`=0 asserted during `WR` → that write completes; no further grants while `ena`=0. Grants resume from the saved `rr_ptr` when `ena` returns to 1.
- `rst_n` pulled low during `RD` → `fifo_rd_en`, `rd_valid` and `req_ready` go 0 immediately. After release, the first tie goes to a write from requester 0.
